// File: rtl/te_pll_sequencer.sv
// PLL bring-up and RX front-end timing sequencer. All outputs are registered
// and decoded from the next state, so no input reaches an output combinationally.
module te_pll_sequencer #(
  parameter int unsigned SETTLE_CYC   = 64,
  parameter int unsigned RX_DLY_CYC   = 16,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned CW           = 16
) (
  input  logic ck,
  input  logic arst,
  input  logic radio_req,
  input  logic rx_req,
  input  logic pll_lock,
  output logic pll_en,
  output logic pll_settled,
  output logic t_arst_fs,
  output logic lock_timeout,
  output logic lock_lost,
  output logic busy
);

  typedef enum logic [2:0] {
    StIdle,
    StPllWait,
    StSettle,
    StReady,
    StRxDly,
    StRxOn,
    StError
  } state_e;

  localparam logic [CW-1:0] SettleLast  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] RxDlyLast   = CW'(RX_DLY_CYC - 1);
  localparam logic [CW-1:0] TimeoutLast = CW'(LOCK_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          pll_en_q, pll_en_d;
  logic          pll_settled_q, pll_settled_d;
  logic          t_arst_fs_q, t_arst_fs_d;
  logic          lock_timeout_q, lock_timeout_d;
  logic          lock_lost_q, lock_lost_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = 1'b0;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    // Branch order encodes event priority: radio drop > lock loss > terminal > rx_req.
    unique case (state_q)
      StIdle: begin
        if (radio_req) state_d = StPllWait;
      end
      StPllWait: begin
        if (!radio_req)                state_d = StIdle;
        else if (pll_lock)             state_d = StSettle;
        else if (cnt_q >= TimeoutLast) state_d = StError;
        else                           cnt_d   = cnt_inc;
      end
      StSettle: begin
        if (!radio_req)               state_d = StIdle;
        else if (!pll_lock)           state_d = StPllWait;
        else if (cnt_q >= SettleLast) state_d = StReady;
        else                          cnt_d   = cnt_inc;
      end
      StReady: begin
        if (!radio_req) begin
          state_d = StIdle;
        end else if (!pll_lock) begin
          state_d     = StPllWait;
          lock_lost_d = 1'b1;
        end else if (rx_req) begin
          state_d = StRxDly;
        end
      end
      StRxDly: begin
        if (!radio_req) begin
          state_d = StIdle;
        end else if (!pll_lock) begin
          state_d     = StPllWait;
          lock_lost_d = 1'b1;
        end else if (cnt_q >= RxDlyLast) begin
          state_d = StRxOn;
        end else if (!rx_req) begin
          state_d = StReady;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRxOn: begin
        if (!radio_req) begin
          state_d = StIdle;
        end else if (!pll_lock) begin
          state_d     = StPllWait;
          lock_lost_d = 1'b1;
        end else if (!rx_req) begin
          state_d = StReady;
        end
      end
      StError: begin
        if (!radio_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) cnt_d = '0;

    pll_en_d       = state_d inside {StPllWait, StSettle, StReady, StRxDly, StRxOn};
    pll_settled_d  = state_d inside {StReady, StRxDly, StRxOn};
    t_arst_fs_d    = (state_d == StRxOn);
    lock_timeout_d = (state_d == StError);
    busy_d         = (state_d != StIdle);
  end

  always_ff @(posedge ck) begin
    if (arst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      pll_en_q       <= 1'b0;
      pll_settled_q  <= 1'b0;
      t_arst_fs_q    <= 1'b0;
      lock_timeout_q <= 1'b0;
      lock_lost_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pll_en_q       <= pll_en_d;
      pll_settled_q  <= pll_settled_d;
      t_arst_fs_q    <= t_arst_fs_d;
      lock_timeout_q <= lock_timeout_d;
      lock_lost_q    <= lock_lost_d;
      busy_q         <= busy_d;
    end
  end

  assign pll_en       = pll_en_q;
  assign pll_settled  = pll_settled_q;
  assign t_arst_fs    = t_arst_fs_q;
  assign lock_timeout = lock_timeout_q;
  assign lock_lost    = lock_lost_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_te_pll_sequencer.sv
// Bench for te_pll_sequencer: directed scenario tasks with literal timing
// expectations, then a randomized run against a behavioural session model.
module tb_te_pll_sequencer;

  localparam int unsigned SettleCyc   = 8;
  localparam int unsigned RxDlyCyc    = 4;
  localparam int unsigned LockTimeout = 20;

  logic ck = 1'b0;
  logic arst, radio_req, rx_req, pll_lock;
  logic pll_en, pll_settled, t_arst_fs, lock_timeout, lock_lost, busy;

  int checks = 0;
  int errors = 0;

  te_pll_sequencer #(
    .SETTLE_CYC  (SettleCyc),
    .RX_DLY_CYC  (RxDlyCyc),
    .LOCK_TIMEOUT(LockTimeout),
    .CW          (8)
  ) dut (
    .ck          (ck),
    .arst        (arst),
    .radio_req   (radio_req),
    .rx_req      (rx_req),
    .pll_lock    (pll_lock),
    .pll_en      (pll_en),
    .pll_settled (pll_settled),
    .t_arst_fs   (t_arst_fs),
    .lock_timeout(lock_timeout),
    .lock_lost   (lock_lost),
    .busy        (busy)
  );

  always #5 ck = ~ck;

  // Inputs set after tick are sampled on the next rising edge; outputs read
  // after tick reflect the edge just taken.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1; radio_req = 1'b0; rx_req = 1'b0; pll_lock = 1'b0;
    tick(); tick();
    arst = 1'b0;
  endtask

  task automatic goto_ready();
    do_reset();
    radio_req = 1'b1; pll_lock = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  // Behavioural model of one radio session.
  bit m_busy, m_on, m_err, m_settled, m_rxon, m_lost;
  int m_nolock;   // lock-less samples while hunting for lock
  int m_lockrun;  // lock samples credited toward settling (0 = still hunting)
  int m_rxrun;    // rx samples credited toward release (0 = no delay pending)

  task automatic model_clear();
    m_busy = 0; m_on = 0; m_err = 0; m_settled = 0; m_rxon = 0; m_lost = 0;
    m_nolock = 0; m_lockrun = 0; m_rxrun = 0;
  endtask

  task automatic model_step(input bit a, input bit r, input bit x, input bit l);
    m_lost = 0;
    if (a || (m_busy && !r)) begin
      model_clear();
    end else if (!m_busy) begin
      if (r) begin
        m_busy = 1; m_on = 1; m_nolock = 0; m_lockrun = 0;
      end
    end else if (m_err) begin
      // stuck until radio drops
    end else if (!m_settled) begin
      if (m_lockrun == 0) begin
        if (l) m_lockrun = 1;
        else if (m_nolock == int'(LockTimeout) - 1) begin m_err = 1; m_on = 0; end
        else m_nolock++;
      end else if (!l) begin
        m_lockrun = 0; m_nolock = 0;
      end else if (m_lockrun == int'(SettleCyc)) begin
        m_settled = 1; m_rxrun = 0; m_rxon = 0;
      end else begin
        m_lockrun++;
      end
    end else if (!l) begin
      m_settled = 0; m_rxon = 0; m_rxrun = 0; m_lost = 1; m_lockrun = 0; m_nolock = 0;
    end else if (m_rxon) begin
      if (!x) m_rxon = 0;
    end else if (m_rxrun > 0) begin
      if (m_rxrun == int'(RxDlyCyc)) begin m_rxon = 1; m_rxrun = 0; end
      else if (!x) m_rxrun = 0;
      else m_rxrun++;
    end else if (x) begin
      m_rxrun = 1;
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; radio_req = 1'b1; rx_req = 1'b1; pll_lock = 1'b1;
    tick(); tick();
    checks++;
    if ({pll_en, pll_settled, t_arst_fs} !== 3'b000) begin
      errors++;
      $display("FAIL reset_en_settled_t: got %b want 000", {pll_en, pll_settled, t_arst_fs});
    end
    checks++;
    if ({lock_timeout, lock_lost, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_to_lost_busy: got %b want 000", {lock_timeout, lock_lost, busy});
    end
    arst = 1'b0;
  endtask

  task automatic test_bringup();
    do_reset();
    radio_req = 1'b1; pll_lock = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      pll_lock = (e >= 3);
      tick();  // outputs now belong to cycle e+1
      checks++;
      if (pll_en !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bringup_en_busy cyc %0d: got en=%b busy=%b want 1 1", e + 1, pll_en, busy);
      end
      checks++;
      if (pll_settled !== (e + 1 >= 12)) begin
        errors++;
        $display("FAIL bringup_settled cyc %0d: got %b want %b", e + 1, pll_settled, (e + 1 >= 12));
      end
    end
  endtask

  task automatic test_rx_path();
    goto_ready();
    for (int k = 0; k <= 12; k++) begin
      rx_req = (k < 10);
      tick();
      checks++;
      if (t_arst_fs !== (k >= 4 && k <= 9) || pll_settled !== 1'b1) begin
        errors++;
        $display("FAIL rx_path T+%0d: got t=%b settled=%b want t=%b settled=1",
                 k + 1, t_arst_fs, pll_settled, (k >= 4 && k <= 9));
      end
    end
  endtask

  task automatic test_settle_glitch();
    do_reset();
    radio_req = 1'b1; pll_lock = 1'b0;
    tick();
    for (int e = 1; e <= 17; e++) begin
      pll_lock = (e != 6);
      tick();
      checks++;
      if (lock_lost !== 1'b0 || pll_en !== 1'b1 || pll_settled !== (e >= 15)) begin
        errors++;
        $display("FAIL settle_glitch edge %0d: got lost=%b en=%b settled=%b want 0 1 %b",
                 e, lock_lost, pll_en, pll_settled, (e >= 15));
      end
    end
  endtask

  task automatic test_lock_loss_rx_on();
    goto_ready();
    rx_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (t_arst_fs !== 1'b1) begin
      errors++;
      $display("FAIL lockloss_pre_rx_on: got t=%b want 1", t_arst_fs);
    end
    pll_lock = 1'b0;
    tick();
    checks++;
    if ({pll_en, pll_settled, t_arst_fs, lock_lost} !== 4'b1001) begin
      errors++;
      $display("FAIL lockloss_edge: got en/set/t/lost=%b want 1001",
               {pll_en, pll_settled, t_arst_fs, lock_lost});
    end
    tick();
    checks++;
    if ({pll_en, pll_settled, t_arst_fs, lock_lost} !== 4'b1000) begin
      errors++;
      $display("FAIL lockloss_after: got en/set/t/lost=%b want 1000",
               {pll_en, pll_settled, t_arst_fs, lock_lost});
    end
    pll_lock = 1'b1;
  endtask

  task automatic test_timeout();
    do_reset();
    radio_req = 1'b1; pll_lock = 1'b0;
    for (int e = 0; e <= 22; e++) begin
      tick();
      checks++;
      if (lock_timeout !== (e >= 20) || pll_en !== (e < 20)) begin
        errors++;
        $display("FAIL timeout cyc %0d: got to=%b en=%b want to=%b en=%b",
                 e + 1, lock_timeout, pll_en, (e >= 20), (e < 20));
      end
    end
    pll_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({lock_timeout, pll_en, pll_settled, busy} !== 4'b1001) begin
        errors++;
        $display("FAIL timeout_sticky: got to/en/set/busy=%b want 1001",
                 {lock_timeout, pll_en, pll_settled, busy});
      end
    end
    radio_req = 1'b0;
    tick();
    checks++;
    if (lock_timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got to=%b busy=%b want 0 0", lock_timeout, busy);
    end
  endtask

  task automatic test_simultaneous();
    goto_ready();
    rx_req = 1'b1;
    tick(); tick();
    radio_req = 1'b0; pll_lock = 1'b0;
    tick();
    checks++;
    if ({pll_en, pll_settled, t_arst_fs, lock_timeout, lock_lost, busy} !== 6'b0) begin
      errors++;
      $display("FAIL simul_drop_vs_loss: got %b want 000000",
               {pll_en, pll_settled, t_arst_fs, lock_timeout, lock_lost, busy});
    end
    goto_ready();
    rx_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (t_arst_fs !== 1'b1) begin
      errors++;
      $display("FAIL simul_pre_reset_rx_on: got t=%b want 1", t_arst_fs);
    end
    arst = 1'b1; pll_lock = 1'b0;
    tick();
    checks++;
    if ({pll_en, pll_settled, t_arst_fs, lock_timeout, lock_lost, busy} !== 6'b0) begin
      errors++;
      $display("FAIL simul_reset_rx_on: got %b want 000000",
               {pll_en, pll_settled, t_arst_fs, lock_timeout, lock_lost, busy});
    end
    arst = 1'b0;
  endtask

  task automatic test_random();
    int lock_off;
    int shown;
    logic [5:0] exp_v, got_v;
    lock_off = 0;
    shown = 0;
    arst = 1'b1; radio_req = 1'b0; rx_req = 1'b0; pll_lock = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 4000; c++) begin
      arst      = ($urandom_range(299) == 0);
      radio_req = ($urandom_range(79) != 0);
      if ($urandom_range(5) == 0) rx_req = ~rx_req;
      if (lock_off > 0) lock_off--;
      else if ($urandom_range(149) == 0) lock_off = 25;
      pll_lock = (lock_off == 0) && ($urandom_range(19) != 0);
      model_step(arst, radio_req, rx_req, pll_lock);
      tick();
      exp_v = {m_on, m_settled, m_rxon, m_err, m_lost, m_busy};
      got_v = {pll_en, pll_settled, t_arst_fs, lock_timeout, lock_lost, busy};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random cyc %0d en/set/t/to/lost/busy: got %b want %b", c, got_v, exp_v);
        end
      end
      checks++;
      if ((t_arst_fs && !pll_settled) || (pll_settled && !pll_en) || (lock_timeout && pll_en)) begin
        errors++;
        $display("FAIL random_invariant cyc %0d: got en/set/t/to=%b want consistent",
                 c, {pll_en, pll_settled, t_arst_fs, lock_timeout});
      end
    end
  endtask

  initial begin
    arst = 1'b1; radio_req = 1'b0; rx_req = 1'b0; pll_lock = 1'b0;
    test_reset();
    test_bringup();
    test_rx_path();
    test_settle_glitch();
    test_lock_loss_rx_on();
    test_timeout();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/te_pll_sequencer.md
Name: te_pll_sequencer

Overview:
Timing-engine sequencer directly upstream of the radio-enable synchroniser stage. Drives the PLL enable, waits for lock plus a programmable settle time, then raises pll_settled. On a receive request it times the RX front-end delay and raises t_arst_fs. The downstream stage registers both outputs into radioEnableSynced and radioRxEnSynced.

Parameters:
SETTLE_CYC, 64, cycles pll_lock must stay high continuously before pll_settled asserts (>=1)
RX_DLY_CYC, 16, cycles after entering RX_DLY before t_arst_fs asserts (>=1)
LOCK_TIMEOUT, 1024, max cycles in PLL_WAIT without lock before error (>=2)
CW, 16, counter width; must satisfy 2^CW > max(SETTLE_CYC, RX_DLY_CYC, LOCK_TIMEOUT)

Ports:
ck  input  1  clock
arst  input  1  synchronous active-high reset, sampled on posedge ck
radio_req  input  1  level request: radio active
rx_req  input  1  level request: receive enable (ignored unless pll_settled)
pll_lock  input  1  raw PLL lock indicator, already synchronous to ck
pll_en  output  1  PLL enable
pll_settled  output  1  PLL locked and settled (feeds pllSettled)
t_arst_fs  output  1  RX front-end timing released (feeds tArstFs)
lock_timeout  output  1  sticky error: lock not achieved in time
lock_lost  output  1  one-cycle pulse: lock dropped after settle
busy  output  1  state != IDLE

Behaviour:
- Clock ck; reset arst is synchronous and active-high. Reset overrides all other inputs in that cycle.
- Reset values: state=IDLE, counter=0, and every output = 0.
- All outputs are registered and decoded from the next state. No combinational input-to-output paths.
- IDLE: all outputs 0. radio_req=1 -> PLL_WAIT with counter cleared. pll_en is high from the cycle after radio_req is sampled.
- PLL_WAIT: pll_en=1.
  - pll_lock=1 -> SETTLE, counter=0.
  - Otherwise counter++. When counter reaches LOCK_TIMEOUT-1 -> ERROR.
- SETTLE: pll_en=1, counter++ each cycle with pll_lock=1.
  - pll_lock=0 -> PLL_WAIT, counter=0. No lock_lost pulse is generated here.
  - Counter reaches SETTLE_CYC-1 with lock still high -> READY.
  - pll_settled rises exactly SETTLE_CYC+1 cycles after the first sampled pll_lock=1.
- READY: pll_en=1, pll_settled=1. rx_req=1 -> RX_DLY, counter=0.
- RX_DLY: pll_settled=1, counter++.
  - Counter reaches RX_DLY_CYC-1 -> RX_ON.
  - rx_req=0 before then -> READY; t_arst_fs never pulses.
- RX_ON: pll_settled=1, t_arst_fs=1. rx_req=0 -> READY; t_arst_fs falls the next cycle.
- Lock loss in READY, RX_DLY or RX_ON:
  - Next state is PLL_WAIT with counter=0.
  - pll_settled and t_arst_fs fall on the same edge.
  - lock_lost pulses high for exactly one cycle.
- ERROR: pll_en=0, lock_timeout=1 (sticky). Leaves only when radio_req=0 -> IDLE, which clears lock_timeout. pll_lock is ignored here.
- radio_req=0 in any state except IDLE -> IDLE next cycle, clearing all outputs. This has priority over lock loss and counter terminal events.
- Simultaneous events in the same cycle, priority high to low: arst > radio_req=0 > pll_lock loss > counter terminal > rx_req.
- Counters saturate and never wrap. The counter is cleared on every state entry.
- Reset mid-operation: outputs drop to 0 on the reset edge. No pulse is emitted on lock_lost.
- Invariants:
  - t_arst_fs=1 implies pll_settled=1.
  - pll_settled=1 implies pll_en=1.
  - lock_timeout=1 implies pll_en=0.

Test Plan:
- Bench parameters for all scenarios: SETTLE_CYC=8, RX_DLY_CYC=4, LOCK_TIMEOUT=20.
- Normal bring-up: arst 2 cycles, radio_req=1 at cycle 0, pll_lock=1 at cycle 3 -> pll_en=1 at cycle 1; pll_settled=1 at cycle 12; busy=1 from cycle 1.
- RX path: from READY, rx_req=1 at cycle T -> t_arst_fs=1 at T+5. rx_req=0 at T+10 -> t_arst_fs=0 at T+11, pll_settled stays 1.
- Settle glitch: pll_lock drops one cycle at the 5th settle cycle -> return to PLL_WAIT, no lock_lost. Relock -> pll_settled 9 cycles after the relock sample.
- Lock loss in RX_ON: pll_lock=0 -> pll_settled and t_arst_fs both 0 next cycle, lock_lost=1 for exactly one cycle, pll_en stays 1.
- Timeout: radio_req=1, pll_lock held 0 -> lock_timeout=1 and pll_en=0 at cycle 21. Asserting pll_lock then has no effect. radio_req=0 -> lock_timeout=0 and busy=0 next cycle.
- Simultaneous events and reset: in RX_DLY, drive radio_req=0 and pll_lock=0 together -> IDLE, lock_lost stays 0. Then assert arst in RX_ON -> all outputs 0 on the next edge.
